// File: rtl/sample_iterator_pkg.sv
// Shared raster package.
//   state_e      : sample iterator FSM states (WAIT_STATE, TEST_STATE)
//   SUB_*        : one-hot subSample encodings for the sample step
//   step_decode  : maps a subSample code and RADIX to the step in fixed point
package sample_iterator_pkg;

    typedef enum logic {
        WAIT_STATE = 1'b0,
        TEST_STATE = 1'b1
    } state_e;

    localparam logic [3:0] SUB_1PX      = 4'b1000;
    localparam logic [3:0] SUB_HALF_PX  = 4'b0100;
    localparam logic [3:0] SUB_QUART_PX = 4'b0010;
    localparam logic [3:0] SUB_EIGHT_PX = 4'b0001;

    // Step = 1 << (radix - k); any code that is not one-hot falls back to 1 px.
    function automatic int unsigned step_decode(input logic [3:0] sub, input int unsigned radix);
        int unsigned k;
        case (sub)
            SUB_HALF_PX:  k = 1;
            SUB_QUART_PX: k = 2;
            SUB_EIGHT_PX: k = 3;
            default:      k = 0;
        endcase
        return 32'd1 << (radix - k);
    endfunction

endpackage

// File: rtl/sample_iterator.sv
// Sample iterator: walks the sample grid of a triangle's bounding box, one sample per cycle,
// x-fastest and bottom row first, and stalls the bounding-box stage while it iterates.
//
// Ports:
//   clk, rst           clock; asynchronous active-low reset
//   tri_R13S           triangle vertices from the bounding-box stage
//   color_R13U         triangle colour
//   box_R13S           box corners [0]=lower-left, [1]=upper-right; [k][0]=x, [k][1]=y
//   validTri_R13H      triangle and box valid
//   subSample_RnnnnU   one-hot step select (1000=1px .. 0001=1/8px)
//   halt_RnnnnH        upstream must hold its R13 inputs
//   tri_R14S           latched triangle
//   color_R14U         latched colour
//   sample_R14S        current sample (x,y)
//   validSamp_R14H     sample_R14S is valid
//
// Build option: define SAMPLE_ITER_BACK_TO_BACK_EN to accept the next triangle on the edge that
// ends the last sample (halt drops during that cycle), giving no bubble between triangles.
module sample_iterator
    import sample_iterator_pkg::*;
#(
    parameter int unsigned SIGFIG = 24,
    parameter int unsigned RADIX  = 10,
    parameter int unsigned VERTS  = 3,
    parameter int unsigned AXIS   = 3,
    parameter int unsigned COLORS = 3
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic signed [SIGFIG-1:0] tri_R13S    [VERTS][AXIS],
    input  logic        [SIGFIG-1:0] color_R13U  [COLORS],
    input  logic signed [SIGFIG-1:0] box_R13S    [2][2],
    input  logic                     validTri_R13H,
    input  logic        [3:0]        subSample_RnnnnU,
    output logic                     halt_RnnnnH,
    output logic signed [SIGFIG-1:0] tri_R14S    [VERTS][AXIS],
    output logic        [SIGFIG-1:0] color_R14U  [COLORS],
    output logic signed [SIGFIG-1:0] sample_R14S [2],
    output logic                     validSamp_R14H
);

    state_e                   state_q, state_d;
    logic signed [SIGFIG-1:0] sample_q [2];
    logic signed [SIGFIG-1:0] sample_d [2];
    logic signed [SIGFIG-1:0] box_q    [2][2];
    logic signed [SIGFIG-1:0] box_d    [2][2];
    logic signed [SIGFIG-1:0] step_q, step_d;
    logic signed [SIGFIG-1:0] tri_q    [VERTS][AXIS];
    logic        [SIGFIG-1:0] color_q  [COLORS];
    logic                     valid_q, valid_d;
    logic                     halt_q, halt_d;
    logic                     load, try_accept, degenerate;
    logic signed [SIGFIG-1:0] x_inc, y_inc;
`ifdef SAMPLE_ITER_BACK_TO_BACK_EN
    logic signed [SIGFIG-1:0] nx_x_inc, nx_y_inc;
`endif

    always_comb begin
        state_d    = state_q;
        sample_d   = sample_q;
        box_d      = box_q;
        step_d     = step_q;
        valid_d    = 1'b0;
        load       = 1'b0;
        try_accept = 1'b0;
        x_inc      = sample_q[0] + step_q;
        y_inc      = sample_q[1] + step_q;
        degenerate = (box_R13S[0][0] > box_R13S[1][0]) || (box_R13S[0][1] > box_R13S[1][1]);

        case (state_q)
            WAIT_STATE: try_accept = validTri_R13H;
            TEST_STATE: begin
                // <= rather than == so a misaligned box still terminates.
                if (x_inc <= box_q[1][0]) begin
                    sample_d[0] = x_inc;
                    valid_d     = 1'b1;
                end else if (y_inc <= box_q[1][1]) begin
                    sample_d[0] = box_q[0][0];
                    sample_d[1] = y_inc;
                    valid_d     = 1'b1;
                end else begin
                    state_d = WAIT_STATE;
`ifdef SAMPLE_ITER_BACK_TO_BACK_EN
                    try_accept = validTri_R13H;
`endif
                end
            end
            default: state_d = WAIT_STATE;
        endcase

        // Degenerate boxes are consumed (halt stays low) but never iterated.
        if (try_accept && !degenerate) begin
            load        = 1'b1;
            box_d       = box_R13S;
            step_d      = SIGFIG'(step_decode(subSample_RnnnnU, RADIX));
            sample_d[0] = box_R13S[0][0];
            sample_d[1] = box_R13S[0][1];
            valid_d     = 1'b1;
            state_d     = TEST_STATE;
        end

`ifdef SAMPLE_ITER_BACK_TO_BACK_EN
        // Release upstream while the last sample is presented so its successor lands next edge.
        nx_x_inc = sample_d[0] + step_d;
        nx_y_inc = sample_d[1] + step_d;
        halt_d   = valid_d && !((nx_x_inc > box_d[1][0]) && (nx_y_inc > box_d[1][1]));
`else
        halt_d = valid_d;
`endif
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= WAIT_STATE;
            sample_q <= '{default: '0};
            box_q    <= '{default: '{default: '0}};
            step_q   <= '0;
            tri_q    <= '{default: '{default: '0}};
            color_q  <= '{default: '0};
            valid_q  <= 1'b0;
            halt_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            sample_q <= sample_d;
            box_q    <= box_d;
            step_q   <= step_d;
            valid_q  <= valid_d;
            halt_q   <= halt_d;
            if (load) begin
                tri_q   <= tri_R13S;
                color_q <= color_R13U;
            end
        end
    end

    assign halt_RnnnnH    = halt_q;
    assign tri_R14S       = tri_q;
    assign color_R14U     = color_q;
    assign sample_R14S    = sample_q;
    assign validSamp_R14H = valid_q;

endmodule

// File: tb/tb_sample_iterator.sv
module tb_sample_iterator;

    localparam int unsigned SIGFIG = 24;
    localparam int unsigned VERTS  = 3;
    localparam int unsigned AXIS   = 3;
    localparam int unsigned COLORS = 3;
`ifdef SAMPLE_ITER_BACK_TO_BACK_EN
    localparam bit B2B = 1'b1;
`else
    localparam bit B2B = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    logic signed [SIGFIG-1:0] tri_in    [VERTS][AXIS];
    logic        [SIGFIG-1:0] color_in  [COLORS];
    logic signed [SIGFIG-1:0] box_in    [2][2];
    logic                     valid_tri;
    logic        [3:0]        sub;
    logic                     halt;
    logic signed [SIGFIG-1:0] tri_out   [VERTS][AXIS];
    logic        [SIGFIG-1:0] color_out [COLORS];
    logic signed [SIGFIG-1:0] sample    [2];
    logic                     valid_samp;

    int total = 0;
    int bad   = 0;
    int exp_x [8];
    int exp_y [8];

    always #5 clk = ~clk;

    sample_iterator dut (
        .clk              (clk),
        .rst              (rst),
        .tri_R13S         (tri_in),
        .color_R13U       (color_in),
        .box_R13S         (box_in),
        .validTri_R13H    (valid_tri),
        .subSample_RnnnnU (sub),
        .halt_RnnnnH      (halt),
        .tri_R14S         (tri_out),
        .color_R14U       (color_out),
        .sample_R14S      (sample),
        .validSamp_R14H   (valid_samp)
    );

    task automatic check(input string tag, input logic signed [63:0] got,
                         input logic signed [63:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", tag, got, want);
        end
    endtask

    task automatic step_clk();
        @(posedge clk);
        #1;
    endtask

    task automatic set_box(input int llx, input int lly, input int urx, input int ury);
        box_in[0][0] = SIGFIG'(llx);
        box_in[0][1] = SIGFIG'(lly);
        box_in[1][0] = SIGFIG'(urx);
        box_in[1][1] = SIGFIG'(ury);
    endtask

    // Expects n consecutive samples from exp_x/exp_y starting now, then a dead cycle.
    task automatic expect_walk(input string tag, input int n);
        for (int i = 0; i < n; i++) begin
            check({tag, "_valid"}, 64'(valid_samp), 1);
            check({tag, "_x"}, 64'(sample[0]), exp_x[i]);
            check({tag, "_y"}, 64'(sample[1]), exp_y[i]);
            check({tag, "_halt"}, 64'(halt), (B2B && i == n - 1) ? 0 : 1);
            step_clk();
        end
        check({tag, "_end_valid"}, 64'(valid_samp), 0);
        check({tag, "_end_halt"}, 64'(halt), 0);
    endtask

    // Presents one triangle for a single accept edge, then withdraws validTri.
    task automatic accept(input int llx, input int lly, input int urx, input int ury,
                          input logic [3:0] s);
        set_box(llx, lly, urx, ury);
        sub       = s;
        valid_tri = 1'b1;
        step_clk();
        valid_tri = 1'b0;
    endtask

    initial begin
        rst       = 1'b0;
        valid_tri = 1'b0;
        sub       = 4'b1000;
        set_box(0, 0, 0, 0);
        for (int v = 0; v < int'(VERTS); v++)
            for (int a = 0; a < int'(AXIS); a++)
                tri_in[v][a] = SIGFIG'(v * 16 + a + 1);
        for (int c = 0; c < int'(COLORS); c++) color_in[c] = SIGFIG'(100 + c);

        step_clk();
        step_clk();
        check("rst_valid", 64'(valid_samp), 0);
        check("rst_halt", 64'(halt), 0);
        check("rst_x", 64'(sample[0]), 0);
        check("rst_y", 64'(sample[1]), 0);
        check("rst_tri", 64'(tri_out[1][2]), 0);
        check("rst_color", 64'(color_out[2]), 0);
        #2 rst = 1'b1;
        step_clk();

        // 1 px walk over a 3x2 grid.
        accept(0, 0, 2048, 1024, 4'b1000);
        check("px1_tri", 64'(tri_out[1][2]), 19);
        check("px1_color", 64'(color_out[2]), 102);
        exp_x = '{0, 1024, 2048, 0, 1024, 2048, 0, 0};
        exp_y = '{0, 0, 0, 1024, 1024, 1024, 0, 0};
        expect_walk("px1", 6);

        // Half-pixel step.
        accept(512, 512, 1024, 1024, 4'b0100);
        exp_x = '{512, 1024, 512, 1024, 0, 0, 0, 0};
        exp_y = '{512, 512, 1024, 1024, 0, 0, 0, 0};
        expect_walk("half", 4);

        // Degenerate box is dropped.
        accept(2048, 0, 1024, 1024, 4'b1000);
        check("degen_valid", 64'(valid_samp), 0);
        check("degen_halt", 64'(halt), 0);
        step_clk();
        check("degen_valid2", 64'(valid_samp), 0);

        // Single-sample box.
        accept(3072, 3072, 3072, 3072, 4'b1000);
        exp_x = '{3072, 0, 0, 0, 0, 0, 0, 0};
        exp_y = '{3072, 0, 0, 0, 0, 0, 0, 0};
        expect_walk("single", 1);

        // Non-one-hot step select falls back to 1 px.
        accept(0, 0, 1024, 0, 4'b0110);
        exp_x = '{0, 1024, 0, 0, 0, 0, 0, 0};
        exp_y = '{0, 0, 0, 0, 0, 0, 0, 0};
        expect_walk("badsub", 2);

        // Two 2-sample triangles with validTri held high.
        set_box(0, 0, 1024, 0);
        sub       = 4'b1000;
        valid_tri = 1'b1;
        step_clk();
        set_box(4096, 0, 5120, 0);
        check("b2b_a0_valid", 64'(valid_samp), 1);
        check("b2b_a0_x", 64'(sample[0]), 0);
        check("b2b_a0_halt", 64'(halt), 1);
        step_clk();
        check("b2b_a1_valid", 64'(valid_samp), 1);
        check("b2b_a1_x", 64'(sample[0]), 1024);
        check("b2b_a1_halt", 64'(halt), B2B ? 0 : 1);
        step_clk();
`ifndef SAMPLE_ITER_BACK_TO_BACK_EN
        check("b2b_bubble_valid", 64'(valid_samp), 0);
        check("b2b_bubble_halt", 64'(halt), 0);
        step_clk();
`endif
        valid_tri = 1'b0;
        check("b2b_b0_valid", 64'(valid_samp), 1);
        check("b2b_b0_x", 64'(sample[0]), 4096);
        step_clk();
        check("b2b_b1_valid", 64'(valid_samp), 1);
        check("b2b_b1_x", 64'(sample[0]), 5120);
        step_clk();
        check("b2b_end_valid", 64'(valid_samp), 0);

        // Reset on the third sample of a 6-sample walk.
        accept(0, 0, 2048, 1024, 4'b1000);
        step_clk();
        step_clk();
        check("rstmid_x", 64'(sample[0]), 2048);
        check("rstmid_valid", 64'(valid_samp), 1);
        #2 rst = 1'b0;
        #1;
        check("rstmid_valid0", 64'(valid_samp), 0);
        check("rstmid_halt0", 64'(halt), 0);
        check("rstmid_x0", 64'(sample[0]), 0);
        step_clk();
        #2 rst = 1'b1;
        step_clk();
        check("rstmid_idle", 64'(valid_samp), 0);
        accept(1024, 2048, 2048, 2048, 4'b1000);
        exp_x = '{1024, 2048, 0, 0, 0, 0, 0, 0};
        exp_y = '{2048, 2048, 0, 0, 0, 0, 0, 0};
        expect_walk("after_rst", 2);

        // Inputs changed during TEST must not disturb the latched walk.
        accept(0, 0, 1024, 1024, 4'b1000);
        set_box(0, 0, 8192, 8192);
        sub          = 4'b0001;
        tri_in[1][2] = SIGFIG'(777);
        check("hold_tri", 64'(tri_out[1][2]), 19);
        exp_x = '{0, 1024, 0, 1024, 0, 0, 0, 0};
        exp_y = '{0, 0, 1024, 1024, 0, 0, 0, 0};
        expect_walk("hold", 4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running want finished");
        $fatal(1, "timeout");
    end

endmodule
